// File: rtl/dual_duty_slew.sv
// Target registers and per-period duty slew limiter for the VIL/VIH threshold PWM channels.
// Duty outputs only move on the 256-clock period boundary, by at most STEP per boundary.
module dual_duty_slew #(
  parameter int unsigned STEP     = 8,
  parameter logic [7:0]  RST_DUTY = 8'h80
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_vld,
  input  logic       wr_sel,
  input  logic [7:0] wr_data,
  output logic [7:0] VIL_duty,
  output logic [7:0] VIH_duty,
  output logic       period_start,
  output logic       settled
);

  localparam int unsigned DUTY_W = 8;
  localparam int unsigned CNT_W  = 8;
  localparam logic [CNT_W-1:0]  CNT_PRE_LAST = CNT_W'(254);
  localparam logic [DUTY_W:0]   STEP_W       = (DUTY_W+1)'(STEP);
  localparam logic [DUTY_W-1:0] STEP_D       = DUTY_W'(STEP);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ps_q, ps_d;
  logic [DUTY_W-1:0] vil_tgt_q, vil_tgt_d;
  logic [DUTY_W-1:0] vih_tgt_q, vih_tgt_d;
  logic [DUTY_W-1:0] vil_duty_q, vil_duty_d;
  logic [DUTY_W-1:0] vih_duty_q, vih_duty_d;

  // One boundary step: jump when within STEP (or unlimited), else move STEP toward target.
  // A step is only taken when the distance exceeds STEP, so it can never overshoot or wrap.
  function automatic logic [DUTY_W-1:0] slew_step(input logic [DUTY_W-1:0] tgt,
                                                  input logic [DUTY_W-1:0] duty);
    logic              up;
    logic [DUTY_W-1:0] mag;
    logic [DUTY_W-1:0] res;
    up  = (tgt > duty);
    mag = up ? (tgt - duty) : (duty - tgt);
    res = duty;
    if (mag == '0) begin
      res = duty;
    end else if ((STEP == 0) || ({1'b0, mag} <= STEP_W)) begin
      res = tgt;
    end else if (up) begin
      res = duty + STEP_D;
    end else begin
      res = duty - STEP_D;
    end
    return res;
  endfunction

  // Next-state: free-running counter, boundary pulse, slew on boundary, target writes.
  always_comb begin
    cnt_d      = cnt_q + CNT_W'(1);
    ps_d       = (cnt_q == CNT_PRE_LAST);
    vil_tgt_d  = vil_tgt_q;
    vih_tgt_d  = vih_tgt_q;
    vil_duty_d = vil_duty_q;
    vih_duty_d = vih_duty_q;

    // Slew reads the pre-write targets, so a write on the boundary edge waits one period.
    if (ps_q) begin
      vil_duty_d = slew_step(vil_tgt_q, vil_duty_q);
      vih_duty_d = slew_step(vih_tgt_q, vih_duty_q);
    end

    if (wr_vld) begin
      if (wr_sel) begin
        vih_tgt_d = wr_data;
      end else begin
        vil_tgt_d = wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      ps_q       <= 1'b0;
      vil_tgt_q  <= RST_DUTY;
      vih_tgt_q  <= RST_DUTY;
      vil_duty_q <= RST_DUTY;
      vih_duty_q <= RST_DUTY;
    end else begin
      cnt_q      <= cnt_d;
      ps_q       <= ps_d;
      vil_tgt_q  <= vil_tgt_d;
      vih_tgt_q  <= vih_tgt_d;
      vil_duty_q <= vil_duty_d;
      vih_duty_q <= vih_duty_d;
    end
  end

  assign VIL_duty     = vil_duty_q;
  assign VIH_duty     = vih_duty_q;
  assign period_start = ps_q;
  assign settled      = (vil_duty_q == vil_tgt_q) && (vih_duty_q == vih_tgt_q);

endmodule

// File: tb/tb_dual_duty_slew.sv
// Bench for dual_duty_slew: integer reference model checked every cycle, plus directed
// scenarios with literal expectations, run on a STEP=8 and a STEP=0 instance in parallel.
module tb_dual_duty_slew;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_vld;
  logic       wr_sel;
  logic [7:0] wr_data;

  logic [7:0] vil_duty, vih_duty;
  logic       period_start, settled;
  logic [7:0] vil_duty0, vih_duty0;
  logic       period_start0, settled0;

  int total = 0;
  int bad   = 0;

  // Reference model state (plain integers)
  int m_cnt;
  int m_tgt   [2];
  int m_duty  [2];
  int m_duty0 [2];
  bit m_valid = 1'b0;

  always #5 clk = ~clk;

  dual_duty_slew #(.STEP(8), .RST_DUTY(8'h80)) dut (
    .clk(clk), .rst(rst), .wr_vld(wr_vld), .wr_sel(wr_sel), .wr_data(wr_data),
    .VIL_duty(vil_duty), .VIH_duty(vih_duty),
    .period_start(period_start), .settled(settled)
  );

  dual_duty_slew #(.STEP(0), .RST_DUTY(8'h80)) dut0 (
    .clk(clk), .rst(rst), .wr_vld(wr_vld), .wr_sel(wr_sel), .wr_data(wr_data),
    .VIL_duty(vil_duty0), .VIH_duty(vih_duty0),
    .period_start(period_start0), .settled(settled0)
  );

  function automatic int slew_ref(input int tgt, input int duty, input int step);
    int d;
    d = tgt - duty;
    if (d == 0) return duty;
    if (step == 0 || (d <= step && d >= -step)) return tgt;
    if (d > 0) return duty + step;
    return duty - step;
  endfunction

  task automatic chk(input string name, input logic [8:0] got, input int exp);
    total++;
    if (got !== 9'(exp)) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, 9'(exp));
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b1;
      m_cnt   <= 0;
      for (int i = 0; i < 2; i++) begin
        m_tgt[i]   <= 'h80;
        m_duty[i]  <= 'h80;
        m_duty0[i] <= 'h80;
      end
    end else if (m_valid) begin
      m_cnt <= (m_cnt + 1) % 256;
      if (m_cnt == 255) begin
        for (int i = 0; i < 2; i++) begin
          m_duty[i]  <= slew_ref(m_tgt[i], m_duty[i], 8);
          m_duty0[i] <= slew_ref(m_tgt[i], m_duty0[i], 0);
        end
      end
      if (wr_vld) m_tgt[wr_sel] <= int'(wr_data);
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_vil",     vil_duty,      m_duty[0]);
      chk("m_vih",     vih_duty,      m_duty[1]);
      chk("m_ps",      period_start,  (m_cnt == 255) ? 1 : 0);
      chk("m_settled", settled,       (m_duty[0] == m_tgt[0] && m_duty[1] == m_tgt[1]) ? 1 : 0);
      chk("m0_vil",    vil_duty0,     m_duty0[0]);
      chk("m0_vih",    vih_duty0,     m_duty0[1]);
      chk("m0_ps",     period_start0, (m_cnt == 255) ? 1 : 0);
      chk("m0_settled", settled0,     (m_duty0[0] == m_tgt[0] && m_duty0[1] == m_tgt[1]) ? 1 : 0);
    end
  end

  task automatic wait_cnt(input int v);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (m_cnt != v && n < 400);
    if (m_cnt != v) chk("wait_cnt_timeout", 9'(m_cnt), v);
  endtask

  task automatic wait_bounds(input int n);
    for (int i = 0; i < n; i++) wait_cnt(0);
  endtask

  task automatic wr(input logic sel, input logic [7:0] data);
    wr_vld  = 1'b1;
    wr_sel  = sel;
    wr_data = data;
    @(negedge clk);
    wr_vld  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_vld = 1'b0; wr_sel = 1'b0; wr_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle after reset: pulses at 255 and 511 only, duties hold at 0x80
    for (int k = 0; k < 600; k++) begin
      if (k == 0)   chk("rst_ps", period_start, 0);
      if (k == 254 || k == 256 || k == 510 || k == 512) chk("idle_ps_low", period_start, 0);
      if (k == 255 || k == 511) chk("idle_ps_high", period_start, 1);
      @(negedge clk);
    end
    chk("idle_vil", vil_duty, 'h80);
    chk("idle_vih", vih_duty, 'h80);
    chk("idle_settled", settled, 1);

    // Back-to-back writes to VIH: last one wins
    wait_cnt(20);
    wr(1'b1, 8'hFF);
    wr(1'b1, 8'h84);
    wait_cnt(0);
    chk("b2b_vih", vih_duty, 'h84);
    chk("b2b_vil", vil_duty, 'h80);
    wr(1'b1, 8'h80);
    wait_cnt(0);
    chk("restore_vih", vih_duty, 'h80);

    // VIH -> 0x90 written at counter 10
    wait_cnt(10);
    wr(1'b1, 8'h90);
    chk("w90_settled_low", settled, 0);
    chk("w90_vih_hold", vih_duty, 'h80);
    wait_cnt(255);
    chk("w90_vih_pre", vih_duty, 'h80);
    wait_cnt(0);
    chk("w90_vih_1", vih_duty, 'h88);
    chk("w90_settled_mid", settled, 0);
    wait_cnt(0);
    chk("w90_vih_2", vih_duty, 'h90);
    chk("w90_settled_high", settled, 1);

    // Write on the period_start cycle waits a full period
    wait_cnt(255);
    wr(1'b0, 8'h85);
    chk("edge_vil_hold", vil_duty, 'h80);
    wait_cnt(0);
    chk("edge_vil_next", vil_duty, 'h85);
    wr(1'b0, 8'h80);
    wait_cnt(0);
    chk("restore_vil", vil_duty, 'h80);

    // VIL -> 0x00 in 16 steps of 8
    wr(1'b0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      wait_cnt(0);
      chk("down_vil", vil_duty, 'h80 - 8 * (i + 1));
      chk("down_vih", vih_duty, 'h90);
    end
    chk("down_settled", settled, 1);

    // Full-scale 0 -> 255 takes 32 boundaries; STEP=0 instance jumps at once
    wr(1'b1, 8'h00);
    wait_bounds(18);
    chk("fs_vih_zero", vih_duty, 'h00);
    wr(1'b0, 8'hFF);
    wr(1'b1, 8'hFF);
    wait_cnt(0);
    chk("fs_vil_1", vil_duty, 'h08);
    chk("s0_vih_jump", vih_duty0, 'hFF);
    chk("s0_vil_jump", vil_duty0, 'hFF);
    wait_bounds(30);
    chk("fs_vil_31", vil_duty, 'hF8);
    wait_cnt(0);
    chk("fs_vil_32", vil_duty, 'hFF);
    chk("fs_settled", settled, 1);

    // Reset mid-slew abandons the slew
    wr(1'b0, 8'h00);
    wr(1'b1, 8'h00);
    wait_bounds(3);
    wait_cnt(100);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_vil", vil_duty, 'h80);
    chk("mrst_vih", vih_duty, 'h80);
    chk("mrst_settled", settled, 1);
    chk("mrst_ps", period_start, 0);
    chk("mrst_vil0", vil_duty0, 'h80);
    repeat (254) @(negedge clk);
    chk("mrst_ps_254", period_start, 0);
    @(negedge clk);
    chk("mrst_ps_255", period_start, 1);
    wait_bounds(2);
    chk("mrst_vil_hold", vil_duty, 'h80);
    chk("mrst_vih_hold", vih_duty, 'h80);

    // Randomized writes and occasional reset
    for (int k = 0; k < 6000; k++) begin
      wr_vld  = ($urandom_range(0, 5) == 0);
      wr_sel  = 1'($urandom_range(0, 1));
      wr_data = 8'($urandom_range(0, 255));
      rst     = ($urandom_range(0, 2999) == 0);
      @(negedge clk);
    end
    wr_vld = 1'b0;
    rst    = 1'b0;
    repeat (300) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
